dcache_assoc: RTL

Parametrised write-back, write-allocate data cache: the next generation of the core's data cache, with configurable set count, line length and 1- or 2-way associativity with LRU replacement. It sits between the memory controller's load/store port and the external memory interface. Tag, valid, dirty and data storage are integrated, and separate writeback and line-fill request/acknowledge handshakes replace the old store/line-fill buffer pulses.

---
 rtl/dcache_pkg.sv | 37 +++
 rtl/dcache_way.sv | 62 ++++++
 rtl/dcache_assoc.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the associative data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    function automatic int calc_off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int calc_idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int calc_tag_w(input int sets, input int line_words);
        return 30 - $clog2(line_words) - $clog2(sets);
    endfunction

    // Field extractors return zero-extended 32-bit values; callers size-cast.
    function automatic logic [31:0] addr_offset(input logic [31:0] addr, input int off_w);
        return (addr >> 2) & ((32'd1 << off_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int off_w,
                                               input int idx_w);
        return (addr >> (off_w + 2)) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int off_w,
                                             input int idx_w);
        return addr >> (off_w + idx_w + 2);
    endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache way: tag/valid/dirty arrays and line storage with word and line write ports.
module dcache_way #(
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 8,
    parameter int IDX_W      = 4,
    parameter int OFF_W      = 3,
    parameter int TAG_W      = 23
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [IDX_W-1:0]        idx_i,
    input  logic [TAG_W-1:0]        tag_i,
    input  logic                    word_we_i,
    input  logic [OFF_W-1:0]        word_off_i,
    input  logic [31:0]             word_data_i,
    input  logic                    line_we_i,
    input  logic [TAG_W-1:0]        line_tag_i,
    input  logic [32*LINE_WORDS-1:0] line_data_i,
    input  logic                    clr_dirty_i,
    output logic                    hit_o,
    output logic                    valid_o,
    output logic                    dirty_o,
    output logic [TAG_W-1:0]        tag_o,
    output logic [32*LINE_WORDS-1:0] line_o
);

    logic [TAG_W-1:0]            tag_mem  [SETS];
    logic [LINE_WORDS-1:0][31:0] data_mem [SETS];
    logic [SETS-1:0]             valid_q;
    logic [SETS-1:0]             dirty_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end else if (clr_dirty_i) begin
            dirty_q[idx_i] <= 1'b0;
        end
    end

    // Tag and data contents are left uninitialised; valid gates their use.
    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            tag_mem[idx_i]  <= line_tag_i;
            data_mem[idx_i] <= line_data_i;
        end else if (word_we_i) begin
            data_mem[idx_i][word_off_i] <= word_data_i;
        end
    end

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_mem[idx_i];
    assign line_o  = data_mem[idx_i];
    assign hit_o   = valid_q[idx_i] && (tag_mem[idx_i] == tag_i);

endmodule

// File: rtl/dcache_assoc.sv
// Write-back, write-allocate 1/2-way data cache with LRU replacement.
// Define DCACHE_STATS_EN to add the HitCount/MissCount ports.
module dcache_assoc
    import dcache_pkg::*;
#(
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 8,
    parameter int WAYS       = 2
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     En,
    input  logic                     RW,
    input  logic [31:0]              Address,
    input  logic [31:0]              WData,
    output logic [31:0]              RData,
    output logic                     Stall,
    output logic                     WB_Req,
    output logic [31:0]              WB_Addr,
    output logic [32*LINE_WORDS-1:0] WB_Data,
    input  logic                     WB_Ack,
    output logic                     Fill_Req,
    output logic [31:0]              Fill_Addr,
    input  logic                     Fill_Ack,
    input  logic [32*LINE_WORDS-1:0] Fill_Data
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]              HitCount,
    output logic [31:0]              MissCount
`endif
);

    localparam int OFF_W  = calc_off_w(LINE_WORDS);
    localparam int IDX_W  = calc_idx_w(SETS);
    localparam int TAG_W  = calc_tag_w(SETS, LINE_WORDS);
    localparam int LINE_W = 32 * LINE_WORDS;

    state_t            state_q;
    logic              wb_req_q, fill_req_q, victim_q;
    logic [31:0]       miss_addr_q;
    logic [OFF_W-1:0]  cur_off;
    logic [IDX_W-1:0]  cur_idx, miss_idx, idx_sel;
    logic [TAG_W-1:0]  cur_tag, miss_tag, victim_tag;
    logic [WAYS-1:0]   hit_v, valid_v, dirty_v, word_we_v, line_we_v, clr_dirty_v;
    logic [TAG_W-1:0]  tag_rd  [WAYS];
    logic [LINE_W-1:0] line_rd [WAYS];
    logic [LINE_W-1:0] victim_line;
    logic [31:0]       rdata;
    logic              hit_any, hit_way, victim_d, victim_dirty, lru_bit;
    logic              hit_access, miss_start, wb_done, fill_done;

    assign cur_off  = OFF_W'(addr_offset(Address, OFF_W));
    assign cur_idx  = IDX_W'(addr_index(Address, OFF_W, IDX_W));
    assign cur_tag  = TAG_W'(addr_tag(Address, OFF_W, IDX_W));
    assign miss_idx = IDX_W'(addr_index(miss_addr_q, OFF_W, IDX_W));
    assign miss_tag = TAG_W'(addr_tag(miss_addr_q, OFF_W, IDX_W));
    // Outside IDLE the arrays are addressed by the latched miss set.
    assign idx_sel  = (state_q == IDLE) ? cur_idx : miss_idx;

    assign hit_access = (state_q == IDLE) && En && hit_any;
    assign miss_start = (state_q == IDLE) && En && !hit_any;
    assign wb_done    = (state_q == WRITEBACK) && WB_Ack;
    assign fill_done  = (state_q == FILL) && Fill_Ack;

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        dcache_way #(
            .SETS(SETS), .LINE_WORDS(LINE_WORDS), .IDX_W(IDX_W), .OFF_W(OFF_W), .TAG_W(TAG_W)
        ) u_way (
            .clk_i(Clk), .rst_i(Rst), .idx_i(idx_sel), .tag_i(cur_tag),
            .word_we_i(word_we_v[gi]), .word_off_i(cur_off), .word_data_i(WData),
            .line_we_i(line_we_v[gi]), .line_tag_i(miss_tag), .line_data_i(Fill_Data),
            .clr_dirty_i(clr_dirty_v[gi]), .hit_o(hit_v[gi]), .valid_o(valid_v[gi]),
            .dirty_o(dirty_v[gi]), .tag_o(tag_rd[gi]), .line_o(line_rd[gi])
        );
        assign word_we_v[gi]   = hit_access && RW && hit_v[gi];
        assign line_we_v[gi]   = fill_done && (victim_q == 1'(gi));
        assign clr_dirty_v[gi] = wb_done && (victim_q == 1'(gi));
    end

    if (WAYS == 2) begin : g_lru
        logic [SETS-1:0] lru_q;  // 1 = way 1 is least recently used
        always_ff @(posedge Clk or posedge Rst) begin
            if (Rst) begin
                lru_q <= '0;
            end else if (hit_access) begin
                lru_q[cur_idx] <= ~hit_way;
            end else if (fill_done) begin
                lru_q[miss_idx] <= ~victim_q;
            end
        end
        assign lru_bit = lru_q[idx_sel];
    end else begin : g_no_lru
        assign lru_bit = 1'b0;
    end

    always_comb begin
        victim_d = lru_bit;
        if (!valid_v[0]) begin
            victim_d = 1'b0;
        end else if (!valid_v[WAYS-1]) begin
            victim_d = 1'b1;
        end
    end

    always_comb begin
        hit_any      = 1'b0;
        hit_way      = 1'b0;
        rdata        = '0;
        victim_dirty = 1'b0;
        victim_tag   = '0;
        victim_line  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_v[w]) begin
                hit_any = 1'b1;
                hit_way = 1'(w);
                rdata   = line_rd[w][{cur_off, 5'b0} +: 32];
            end
            if (victim_d == 1'(w)) begin
                victim_dirty = dirty_v[w];
            end
            if (victim_q == 1'(w)) begin
                victim_tag  = tag_rd[w];
                victim_line = line_rd[w];
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= IDLE;
            wb_req_q    <= 1'b0;
            fill_req_q  <= 1'b0;
            victim_q    <= 1'b0;
            miss_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (miss_start) begin
                    victim_q    <= victim_d;
                    miss_addr_q <= {Address[31:OFF_W+2], {(OFF_W+2){1'b0}}};
                    if (victim_dirty) begin
                        state_q  <= WRITEBACK;
                        wb_req_q <= 1'b1;
                    end else begin
                        state_q    <= FILL;
                        fill_req_q <= 1'b1;
                    end
                end
                WRITEBACK: if (WB_Ack) begin
                    state_q    <= FILL;
                    wb_req_q   <= 1'b0;
                    fill_req_q <= 1'b1;
                end
                FILL: if (Fill_Ack) begin
                    state_q    <= IDLE;
                    fill_req_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign RData     = hit_access ? rdata : 32'd0;
    assign Stall     = (state_q != IDLE) || (En && !hit_any);
    assign WB_Req    = wb_req_q;
    assign WB_Addr   = {victim_tag, miss_idx, {(OFF_W+2){1'b0}}};
    assign WB_Data   = victim_line;
    assign Fill_Req  = fill_req_q;
    assign Fill_Addr = miss_addr_q;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (En && !Stall) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (miss_start)   miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end
    assign HitCount  = hit_cnt_q;
    assign MissCount = miss_cnt_q;
`endif

endmodule
